// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int INSTR_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_pc.sv
// Program counter register: word-aligned redirect load and +INSTR_BYTES advance.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              inc_en,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Load wins over increment; the FSM never asserts both in one cycle.
    always_comb begin
        pc_d = pc_q;
        if (load_en) begin
            pc_d = load_addr & ~ADDR_W'(INSTR_BYTES - 1);
        end else if (inc_en) begin
            pc_d = pc_q + ADDR_W'(INSTR_BYTES);
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule : fetch_pc

// File: rtl/instruction_fetch.sv
// Fetch controller: IDLE -> REQ -> WRITE, driving the instruction register.
// Optional REQ timeout with fetch_err pulse is enabled by defining FETCH_TIMEOUT_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_start,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               IRWRITE,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               fetch_err
);

    if (RESET_PC[1:0] != 2'b00 || TIMEOUT < 1) begin : g_param_check
        $error("instruction_fetch: RESET_PC must be word aligned and TIMEOUT >= 1");
    end

    fetch_state_e       state_d, state_q;
    logic               mem_req_d, mem_req_q;
    logic               irwrite_d, irwrite_q;
    logic               busy_d, busy_q;
    logic [INSTR_W-1:0] instr_d, instr_q;
    logic               pc_load_en;
    logic               pc_inc_en;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             err_d, err_q;
`endif

    fetch_pc #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_fetch_pc (
        .clk      (clk),
        .reset    (reset),
        .load_en  (pc_load_en),
        .inc_en   (pc_inc_en),
        .load_addr(pc_in),
        .pc       (pc)
    );

    // Outputs are computed for the next state and registered with it.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        mem_req_d  = 1'b0;
        irwrite_d  = 1'b0;
        busy_d     = 1'b1;
        instr_d    = instr_q;
        pc_load_en = 1'b0;
        pc_inc_en  = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d     = 1'b0;
                pc_load_en = pc_load;
                if (fetch_start) begin
                    state_d   = ST_REQ;
                    mem_req_d = 1'b1;
                    busy_d    = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    instr_d   = mem_rdata;
                    state_d   = ST_WRITE;
                    irwrite_d = 1'b1;
                end else begin
                    mem_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_W'(1);
                    // This is the TIMEOUT-th REQ cycle without data: give up.
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                        busy_d    = 1'b0;
                        err_d     = 1'b1;
                    end
`endif
                end
            end
            ST_WRITE: begin
                pc_inc_en = 1'b1;
                state_d   = ST_IDLE;
                busy_d    = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            irwrite_q <= 1'b0;
            busy_q    <= 1'b0;
            instr_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            irwrite_q <= irwrite_d;
            busy_q    <= busy_d;
            instr_q   <= instr_d;
`ifdef FETCH_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = pc;
    assign IRWRITE   = irwrite_q;
    assign busy      = busy_q;
    assign instr_out = instr_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: transaction-level model plus directed cases.
module tb_instruction_fetch;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_in = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] instr_out;
    logic        IRWRITE;
    logic [31:0] pc;
    logic        busy;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;

    instruction_fetch #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_start(fetch_start),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .instr_out  (instr_out),
        .IRWRITE    (IRWRITE),
        .pc         (pc),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: a fetch is either waiting for memory or being delivered.
    bit          m_waiting;
    bit          m_delivering;
    bit          m_err;
    int          m_wait_cycles;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_waiting     = 1'b0;
            m_delivering  = 1'b0;
            m_err         = 1'b0;
            m_wait_cycles = 0;
            m_pc          = RESET_PC;
            m_instr       = '0;
        end else begin
            m_err = 1'b0;
            if (m_delivering) begin
                m_delivering = 1'b0;
                m_pc = m_pc + 32'd4;
            end else if (m_waiting) begin
                if (mem_ready) begin
                    m_instr      = mem_rdata;
                    m_waiting    = 1'b0;
                    m_delivering = 1'b1;
                end else begin
                    m_wait_cycles++;
`ifdef FETCH_TIMEOUT_EN
                    if (m_wait_cycles == TIMEOUT) begin
                        m_waiting = 1'b0;
                        m_err     = 1'b1;
                    end
`endif
                end
            end else begin
                if (pc_load) m_pc = {pc_in[31:2], 2'b00};
                if (fetch_start) begin
                    m_waiting     = 1'b1;
                    m_wait_cycles = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("cmp_mem_req", mem_req, m_waiting);
            if (m_waiting) check("cmp_mem_addr", mem_addr, m_pc);
            check("cmp_irwrite", IRWRITE, m_delivering);
            check("cmp_instr_out", instr_out, m_instr);
            check("cmp_pc", pc, m_pc);
            check("cmp_busy", busy, m_waiting || m_delivering);
            check("cmp_fetch_err", fetch_err, m_err);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int n_req;
        reset = 1'b0;
        tick();
        tick();
        check("rst_pc", pc, 32'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_irwrite", IRWRITE, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_err", fetch_err, 1'b0);
        reset = 1'b1;
        checking = 1'b1;
        tick();

        // Single fetch, memory answers in the first REQ cycle.
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("f1_mem_req", mem_req, 1'b1);
        check("f1_mem_addr", mem_addr, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h8C22_0004;
        tick();
        mem_ready = 1'b0;
        check("f1_irwrite", IRWRITE, 1'b1);
        check("f1_instr", instr_out, 32'h8C22_0004);
        check("f1_pc_before", pc, 32'h0);
        tick();
        check("f1_irwrite_off", IRWRITE, 1'b0);
        check("f1_pc_after", pc, 32'h4);

        // Five wait cycles; fetch_start pulses while busy must be ignored.
        fetch_start = 1'b1;
        tick();
        n_req = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_req && mem_addr == 32'h4) n_req++;
            fetch_start = 1'b1;
            mem_ready   = (i == 5);
            mem_rdata   = 32'h0011_2233;
            tick();
        end
        fetch_start = 1'b0;
        mem_ready   = 1'b0;
        check("w5_req_cycles", n_req, 6);
        check("w5_irwrite", IRWRITE, 1'b1);
        check("w5_instr", instr_out, 32'h0011_2233);
        tick();
        check("w5_pc", pc, 32'h8);
        check("w5_idle", busy, 1'b0);

        // Redirect and fetch in the same cycle: fetch uses the aligned target.
        pc_load     = 1'b1;
        pc_in       = 32'h0040_0013;
        fetch_start = 1'b1;
        tick();
        pc_load     = 1'b0;
        fetch_start = 1'b0;
        check("rd_mem_addr", mem_addr, 32'h0040_0010);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        check("rd_pc_after", pc, 32'h0040_0014);

        // PC wraps; pc_load during REQ is ignored.
        pc_load = 1'b1;
        pc_in   = 32'hFFFF_FFFE;
        tick();
        pc_load = 1'b0;
        check("wrap_pc_load", pc, 32'hFFFF_FFFC);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        pc_load     = 1'b1;
        pc_in       = 32'h0000_1234;
        tick();
        pc_load   = 1'b0;
        mem_ready = 1'b1;
        check("req_pc_load_ignored", pc, 32'hFFFF_FFFC);
        tick();
        mem_ready = 1'b0;
        tick();
        check("wrap_pc", pc, 32'h0);

        // Asynchronous reset while in REQ.
        pc_load = 1'b1;
        pc_in   = 32'h0000_0100;
        tick();
        pc_load     = 1'b0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        check("ar_mem_req_before", mem_req, 1'b1);
        reset = 1'b0;
        #1;
        check("ar_mem_req", mem_req, 1'b0);
        check("ar_irwrite", IRWRITE, 1'b0);
        check("ar_pc", pc, RESET_PC);
        mem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("ar_no_irwrite", IRWRITE, 1'b0);
        check("ar_busy", busy, 1'b0);
        mem_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        begin
            int n_cyc;
            fetch_start = 1'b1;
            tick();
            fetch_start = 1'b0;
            n_cyc = 0;
            while (!fetch_err && n_cyc < 40) begin
                tick();
                n_cyc++;
            end
            check("to_cycles", n_cyc, TIMEOUT);
            check("to_pc", pc, RESET_PC);
            check("to_busy", busy, 1'b0);
            check("to_irwrite", IRWRITE, 1'b0);
            tick();
            check("to_err_once", fetch_err, 1'b0);
        end
`endif

        // Randomized traffic against the model, with rare async resets.
        for (int i = 0; i < 3000; i++) begin
            fetch_start = ($urandom_range(0, 2) == 0);
            pc_load     = ($urandom_range(0, 4) == 0);
            pc_in       = $urandom;
            mem_ready   = ($urandom_range(0, 3) == 0);
            mem_rdata   = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_instruction_fetch
